median_window_3x3: RTL and testbench
====================================

// Module: median_window_3x3
// PURPOSE
//  Builds 3x3 pixel windows from a raster pixel stream, for the median-filter datapath.
//  Feeds the downstream 3-input max/min/median compare network.
//  Each valid window gives three rows of three pixels, fully inside the image (no border padding).
//  Two lines of history are held in one on-chip line RAM.
// PARAMETERS
//  DW     8    pixel width, bits
//  IMG_W  640  pixels per line; must be >= 3
//  IMG_H  480  lines per frame; must be >= 3
// PORTS
//  clk        in   1     single clock; all logic on rising edge
//  rst_n      in   1     synchronous, active-low reset
//  pix_vld    in   1     pix_data/pix_sof are valid this cycle
//  pix_sof    in   1     qualified by pix_vld; this pixel is (row 0, col 0)
//  pix_data   in   DW    input pixel, raster order
//  win_vld    out  1     window outputs valid this cycle
//  win_r0     out  3*DW  oldest row (r-2) of the window
//  win_r1     out  3*DW  middle row (r-1) of the window
//  win_r2     out  3*DW  newest row (r) of the window
//  win_eol    out  1     with win_vld: last window of a line (c == IMG_W-1)
//  win_eof    out  1     with win_vld: last window of the frame (r == IMG_H-1, c == IMG_W-1)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - col/row counters = 0; pipeline valids = 0; win_vld/win_eol/win_eof = 0.
//    - Window registers and win_r* = 0.
//    - Line RAM contents are not cleared; row gating makes stale data invisible.
//  - Counters (col 0..IMG_W-1, row 0..IMG_H-1):
//    - Advance only on pix_vld.
//    - col wraps to 0 and increments row; row wraps to 0 after IMG_H-1, so frames run back to back.
//    - pix_vld & pix_sof forces this pixel to (0,0) at any point, re-syncing mid-frame; no error flag.
//  - Line RAM: depth IMG_W, width 2*DW, address = col, read-first.
//    - Accept cycle t reads {l1,l2} (rows r-1, r-2 at col c) and writes {pix_data, l1}.
//  - Pipeline, stage 1 (edge t):
//    - Register pix_data, col, row, eol/eof tags and s1_vld.
//    - The RAM read completes on the same edge.
//  - Pipeline, stage 2 (edge t+1, only if s1_vld):
//    - Shift the window left by one column.
//    - Load {l2, l1, pix} as the new right-hand column.
//  - Output timing:
//    - win_vld is high in the cycle after edge t+1; fixed latency 2 clocks.
//    - Condition: accepted pixel had row >= 2 and col >= 2.
//  - Packing: bits [DW-1:0] = newest column (c), [2DW-1:DW] = c-1, [3DW-1:2DW] = c-2.
//  - Window content for pixel (r,c): rows r-2..r, cols c-2..c, centre (r-1, c-1).
//  - Count: exactly (IMG_W-2)*(IMG_H-2) windows per complete frame.
//  - Flow control:
//    - Gaps in pix_vld freeze all state; win_vld is low for the matching cycles 2 later.
//    - No backpressure; the consumer is always ready.
//  - Line wrap: columns from the previous line may remain in the window registers.
//    They never appear, because col < 2 suppresses win_vld.
//  - win_r*, win_eol and win_eof hold their last values while win_vld = 0.
//  - Simultaneous sof and counter wrap: sof wins.
//  - Reset during a frame: outputs go idle next cycle; the next pixel is treated as (0,0).
//  - Timing: no arithmetic beyond counter increments. Counter widths are $clog2(IMG_W) and $clog2(IMG_H).
// STRUCTURE
//  - Shared package median_pkg:
//    - DW, IMG_W, IMG_H defaults.
//    - COL_W = $clog2(IMG_W), ROW_W = $clog2(IMG_H).
//    - Window packing offsets; reused by the compare stages.
//  - Sub-module line_ram:
//    - Single-port, read-first, synchronous read.
//    - Parameters DEPTH, WIDTH; infers block RAM.
//    - One instance, WIDTH = 2*DW, DEPTH = IMG_W.
//  - Remaining logic in this module: counters, stage-1 regs, 3x3 shift regs, tag logic.
// TESTING (IMG_W=4, IMG_H=4, DW=8, pixel value = 4*row + col)
//  1 Continuous frame, sof on pixel 0:
//    - Exactly 4 win_vld pulses, at pixels 10, 11, 14, 15 (+2 clk).
//    - First: win_r0=00_01_02, win_r1=04_05_06, win_r2=08_09_0A.
//    - Last: win_r2=0D_0E_0F, with win_eol=1 and win_eof=1.
//  2 Same frame, pix_vld toggling 1-0-1-0:
//    - Identical window data and flags.
//    - Each win_vld arrives exactly 2 clk after its pixel.
//  3 Two frames back to back, second with values +0x40 and no sof:
//    - Second frame gives 4 windows; first is 40_41_42 / 44_45_46 / 48_49_4A.
//  4 sof asserted at pixel 6 of frame 1, then a full frame:
//    - No window from the aborted frame's stale rows.
//    - The new frame yields the same 4 windows as scenario 1.
//  5 rst_n low for 1 cycle after pixel 11:
//    - win_vld low from the next cycle.
//    - A following full frame (with sof) matches scenario 1 exactly.
//  6 Default 640x480 random frame vs a software 3x3 window model:
//    - 638*478 windows, all matching; win_eof exactly once.

Source files
------------

// File: rtl/median_pkg.sv
// Shared definitions for the median-filter datapath.
//   - Default geometry and pixel width of the window builder.
//   - Counter widths derived from the default geometry.
//   - Column offsets inside a packed window row. The downstream
//     compare stages reuse these offsets.
//   - Per-pixel tag carried alongside the pixel through stage 1.
package median_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_IMG_W = 640;
  localparam int unsigned DEF_IMG_H = 480;

  localparam int unsigned DEF_COL_W = $clog2(DEF_IMG_W);
  localparam int unsigned DEF_ROW_W = $clog2(DEF_IMG_H);

  // A packed window row is three pixels. The newest column (c) sits in
  // the lowest slot and the oldest column (c-2) in the highest slot.
  localparam int unsigned WIN_COLS = 3;
  localparam int unsigned WIN_NEW  = 0;  // column c
  localparam int unsigned WIN_MID  = 1;  // column c-1
  localparam int unsigned WIN_OLD  = 2;  // column c-2

  // Returns the lsb of window column slot 'slot' for pixel width 'dw'.
  function automatic int unsigned win_lsb(input int unsigned slot,
                                          input int unsigned dw);
    return slot * dw;
  endfunction

  // Tag attached to each accepted pixel. It is derived from the raster
  // position so that stage 2 needs no counter comparisons.
  typedef struct packed {
    logic win_ok;  // row >= 2 and col >= 2: a full window ends here
    logic eol;     // last column of a line
    logic eof;     // last column of the last line
  } pix_tag_t;

endpackage

// File: rtl/median_window_3x3_if.sv
// Pixel-stream in / window-stream out bundle for median_window_3x3.
//   pix_vld, pix_sof, pix_data : raster pixel stream (source -> builder)
//   win_vld                    : a window is presented this cycle
//   win_r0, win_r1, win_r2     : window rows r-2, r-1, r (3 pixels each)
//   win_eol, win_eof           : last window of a line / of a frame
// The builder connects through 'slave'. A pixel source that also
// consumes windows connects through 'master'.
interface median_window_3x3_if
  import median_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);

  logic                         pix_vld;
  logic                         pix_sof;
  logic [DW-1:0]                pix_data;

  logic                         win_vld;
  logic [WIN_COLS*DW-1:0]       win_r0;
  logic [WIN_COLS*DW-1:0]       win_r1;
  logic [WIN_COLS*DW-1:0]       win_r2;
  logic                         win_eol;
  logic                         win_eof;

  modport master (
    output pix_vld, pix_sof, pix_data,
    input  win_vld, win_r0, win_r1, win_r2, win_eol, win_eof
  );

  modport slave (
    input  pix_vld, pix_sof, pix_data,
    output win_vld, win_r0, win_r1, win_r2, win_eol, win_eof
  );

endinterface

// File: rtl/median_window_3x3_line_ram.sv
// Line history RAM for the 3x3 window builder.
//   clk       : clock, all activity on the rising edge
//   en        : access strobe (one accepted pixel)
//   addr      : entry address (column)
//   push_data : newest line's pixel for this column
//   rdata     : {upper, lower} halves of the entry before this access
// Single port, read-first, synchronous read. Each entry holds two line
// samples of one column. An access returns the old entry and rewrites
// it as {push_data, old upper half}, so the upper half always carries
// the most recent line and the lower half the line before it.
module line_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH/2-1:0]       push_data,
  output logic [WIDTH-1:0]         rdata
);

  localparam int unsigned HW = WIDTH / 2;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never cleared; the consumer's row gating hides any
  // stale lines left over from reset or an aborted frame.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= {push_data, mem[addr][WIDTH-1 -: HW]};
    end
  end

endmodule

// File: rtl/median_window_3x3.sv
// 3x3 window builder for the median-filter datapath.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   io     : pixel stream in, window stream out (see median_window_3x3_if)
// Pixels arrive in raster order. Every accepted pixel at (r, c) with
// r >= 2 and c >= 2 produces the window rows r-2..r, cols c-2..c,
// two clocks after acceptance. Two lines of history live in a single
// line RAM addressed by column. Gaps in pix_vld freeze all state.
module median_window_3x3
  import median_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 rst_n,
  median_window_3x3_if.slave   io
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned RW    = WIN_COLS * DW;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  localparam int unsigned LSB_NEW = win_lsb(WIN_NEW, DW);
  localparam int unsigned LSB_MID = win_lsb(WIN_MID, DW);

  // ---------------------------------------------------------------
  // Raster position of the incoming pixel
  // ---------------------------------------------------------------
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  pix_tag_t         pix_tag;

  // sof overrides the running counters, which also makes it win over a
  // simultaneous wrap.
  always_comb begin
    pix_col        = col_q;
    pix_row        = row_q;
    if (io.pix_sof) begin
      pix_col      = '0;
      pix_row      = '0;
    end
    pix_tag        = '0;
    pix_tag.win_ok = (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
    pix_tag.eol    = (pix_col == COL_LAST);
    pix_tag.eof    = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (io.pix_vld) begin
      if (pix_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
      end else begin
        col_q <= pix_col + COL_W'(1);
        row_q <= pix_row;
      end
    end
  end

  // ---------------------------------------------------------------
  // Line history: upper half = row r-1, lower half = row r-2
  // ---------------------------------------------------------------
  logic [2*DW-1:0] ram_rd;
  logic [DW-1:0]   hist_l1;
  logic [DW-1:0]   hist_l2;

  line_ram #(
    .DEPTH (IMG_W),
    .WIDTH (2 * DW)
  ) u_line_ram (
    .clk       (clk),
    .en        (io.pix_vld),
    .addr      (pix_col),
    .push_data (io.pix_data),
    .rdata     (ram_rd)
  );

  assign hist_l1 = ram_rd[2*DW-1:DW];
  assign hist_l2 = ram_rd[DW-1:0];

  // ---------------------------------------------------------------
  // Stage 1: pixel and tags, aligned with the RAM read data
  // ---------------------------------------------------------------
  logic          s1_vld;
  logic [DW-1:0] s1_pix;
  pix_tag_t      s1_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pix <= '0;
      s1_tag <= '0;
    end else begin
      s1_vld <= io.pix_vld;
      if (io.pix_vld) begin
        s1_pix <= io.pix_data;
        s1_tag <= pix_tag;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: 3x3 shift window and output registers
  // ---------------------------------------------------------------
  logic [RW-1:0] win0_q, win1_q, win2_q;
  logic [RW-1:0] win0_nxt, win1_nxt, win2_nxt;

  // Shift left by one column; the new column enters the newest slot.
  always_comb begin
    win0_nxt = {win0_q[LSB_MID +: DW], win0_q[LSB_NEW +: DW], hist_l2};
    win1_nxt = {win1_q[LSB_MID +: DW], win1_q[LSB_NEW +: DW], hist_l1};
    win2_nxt = {win2_q[LSB_MID +: DW], win2_q[LSB_NEW +: DW], s1_pix};
  end

  // The shift registers run on every accepted pixel, but the outputs
  // only load when a complete window is present, so they hold their
  // last window across line starts and idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win0_q     <= '0;
      win1_q     <= '0;
      win2_q     <= '0;
      io.win_vld <= 1'b0;
      io.win_r0  <= '0;
      io.win_r1  <= '0;
      io.win_r2  <= '0;
      io.win_eol <= 1'b0;
      io.win_eof <= 1'b0;
    end else begin
      io.win_vld <= s1_vld && s1_tag.win_ok;
      if (s1_vld) begin
        win0_q <= win0_nxt;
        win1_q <= win1_nxt;
        win2_q <= win2_nxt;
        if (s1_tag.win_ok) begin
          io.win_r0  <= win0_nxt;
          io.win_r1  <= win1_nxt;
          io.win_r2  <= win2_nxt;
          io.win_eol <= s1_tag.eol;
          io.win_eof <= s1_tag.eof;
        end
      end
    end
  end

endmodule

// File: tb/tb_median_window_3x3.sv
module tb_median_window_3x3;

  localparam int unsigned DW = 8;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  median_window_3x3_if #(.DW(DW)) io ();

  median_window_3x3 #(
    .DW    (DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct {
    logic [23:0] r0;
    logic [23:0] r1;
    logic [23:0] r2;
    logic        eol;
    logic        eof;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int win_cnt = 0;
  int eof_cnt = 0;
  int m_win_total = 0;
  int m_eof_total = 0;

  // Reference image memory and raster position of the next pixel
  logic [7:0] img [H][W];
  int m_r = 0;
  int m_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [79:0] act,
                                input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: every pixel landing at row>=2, col>=2 closes a window made
  // of the 3x3 block of image pixels ending at it, due two clocks later.
  function automatic void model_accept(input logic sof, input logic [7:0] d);
    exp_t e;
    if (sof) begin
      m_r = 0;
      m_c = 0;
    end
    img[m_r][m_c] = d;
    if (m_r >= 2 && m_c >= 2) begin
      e.r0  = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c]};
      e.r1  = {img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c]};
      e.r2  = {img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
      e.eol = (m_c == W - 1);
      e.eof = (m_c == W - 1) && (m_r == H - 1);
      e.cyc = cyc + 2;
      q.push_back(e);
      m_win_total++;
      if (e.eof) m_eof_total++;
    end
    m_c++;
    if (m_c == W) begin
      m_c = 0;
      m_r = (m_r + 1) % H;
    end
  endfunction

  // ---------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------
  logic        prev_rst = 1'b0;
  logic [23:0] l0 = '0, l1 = '0, l2 = '0;
  logic        le = 1'b0, lf = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!prev_rst) begin
      check("reset_state", {io.win_vld, io.win_r0, io.win_r1, io.win_r2, io.win_eol, io.win_eof}, '0);
      l0 = '0; l1 = '0; l2 = '0; le = 1'b0; lf = 1'b0;
    end else if (io.win_vld) begin
      win_cnt++;
      if (io.win_eof) eof_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL win_unexpected: got win_vld=1, want no window (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("win_latency", 80'(cyc), 80'(e.cyc));
        check("win_r0", 80'(io.win_r0), 80'(e.r0));
        check("win_r1", 80'(io.win_r1), 80'(e.r1));
        check("win_r2", 80'(io.win_r2), 80'(e.r2));
        check("win_eol", 80'(io.win_eol), 80'(e.eol));
        check("win_eof", 80'(io.win_eof), 80'(e.eof));
      end
      l0 = io.win_r0; l1 = io.win_r1; l2 = io.win_r2; le = io.win_eol; lf = io.win_eof;
    end else begin
      check("hold", {io.win_r0, io.win_r1, io.win_r2, io.win_eol, io.win_eof},
            {l0, l1, l2, le, lf});
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL win_missing: got win_vld=0, want window due at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
    end
    prev_rst = rst_n;
  end

  // ---------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------
  task automatic px(input logic sof, input logic [7:0] d);
    @(posedge clk); #1;
    io.pix_vld  = 1'b1;
    io.pix_sof  = sof;
    io.pix_data = d;
    model_accept(sof, d);
  endtask

  // Idle cycles carry junk on data/sof to show they are ignored without pix_vld
  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      io.pix_vld  = 1'b0;
      io.pix_sof  = 1'($urandom_range(0, 1));
      io.pix_data = 8'($urandom);
    end
  endtask

  task automatic frame(input logic [7:0] base, input logic with_sof, input bit toggle);
    for (int i = 0; i < W * H; i++) begin
      px(with_sof && (i == 0), base + 8'(i));
      if (toggle) gap(1);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n      = 1'b0;
    io.pix_vld = 1'b0;
    io.pix_sof = 1'b0;
    // Windows not yet registered by the first reset edge are lost
    while (q.size() > 0 && q[q.size()-1].cyc > cyc) begin
      if (q[q.size()-1].eof) m_eof_total--;
      m_win_total--;
      void'(q.pop_back());
    end
    m_r = 0;
    m_c = 0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic scen_counts(input string name, input int w0, input int f0,
                             input int want_w, input int want_f);
    check({name, "_windows"}, 80'(win_cnt - w0), 80'(want_w));
    check({name, "_eofs"}, 80'(eof_cnt - f0), 80'(want_f));
  endtask

  initial begin
    int w0;
    int f0;
    io.pix_vld  = 1'b0;
    io.pix_sof  = 1'b0;
    io.pix_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    gap(2);

    // 1: continuous frame with sof
    w0 = win_cnt; f0 = eof_cnt;
    frame(8'h00, 1'b1, 1'b0);
    gap(4);
    scen_counts("s1", w0, f0, 4, 1);
    check("s1_last_r2", 80'(l2), 80'(24'h0D0E0F));
    check("s1_last_tags", 80'({le, lf}), 80'(2'b11));

    // 2: pix_vld toggling
    w0 = win_cnt; f0 = eof_cnt;
    frame(8'h00, 1'b1, 1'b1);
    gap(4);
    scen_counts("s2", w0, f0, 4, 1);

    // 3: two frames back to back, second without sof
    w0 = win_cnt; f0 = eof_cnt;
    frame(8'h00, 1'b1, 1'b0);
    frame(8'h40, 1'b0, 1'b0);
    gap(4);
    scen_counts("s3", w0, f0, 8, 2);
    check("s3_last_r0", 80'(l0), 80'(24'h454647));

    // 4: frame aborted by sof at pixel 6
    w0 = win_cnt; f0 = eof_cnt;
    for (int i = 0; i < 6; i++) px(i == 0, 8'(8'h80 + i));
    frame(8'h00, 1'b1, 1'b0);
    gap(4);
    scen_counts("s4", w0, f0, 4, 1);
    check("s4_last_r2", 80'(l2), 80'(24'h0D0E0F));

    // 5: reset after pixel 11, then a full frame
    w0 = win_cnt; f0 = eof_cnt;
    for (int i = 0; i < 12; i++) px(i == 0, 8'(i));
    do_reset(1);
    frame(8'h00, 1'b1, 1'b0);
    gap(4);
    scen_counts("s5", w0, f0, 5, 1);

    // 6: random frames, random gaps, occasional mid-frame sof and one reset
    for (int f = 0; f < 40; f++) begin
      int rst_at;
      rst_at = (f == 20) ? int'($urandom_range(0, W * H - 1)) : -1;
      for (int i = 0; i < W * H; i++) begin
        logic sof;
        sof = (i == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) < 3);
        px(sof, 8'($urandom));
        if ($urandom_range(0, 9) < 3) gap(int'($urandom_range(1, 2)));
        if (i == rst_at) begin
          do_reset(int'($urandom_range(1, 2)));
          break;
        end
      end
    end

    gap(6);
    check("pending_windows", 80'(q.size()), 80'(0));
    check("total_windows", 80'(win_cnt), 80'(m_win_total));
    check("total_eofs", 80'(eof_cnt), 80'(m_eof_total));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
